// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle datapath: HP width, resolver
// state encoding, attacker encoding and the hit rule.
package pbs_pkg;

    localparam int HP_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROLL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic ATK_PLAYER = 1'b0;
    localparam logic ATK_AI     = 1'b1;

    // Accuracy 15 is a sure hit; otherwise the 4-bit roll must fall below it.
    function automatic logic roll_hits(input logic [3:0] roll, input logic [3:0] accu);
        return (accu == 4'hF) || (roll < accu);
    endfunction

endpackage

// File: rtl/move_resolver_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting every cycle
// out of reset. Kept standalone so other blocks can draw their own sequence.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [7:0] q
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/move_resolver.sv
// Resolves one attack per start pulse: rolls accuracy against the LFSR, then
// drains the target's HP one point per drain tick. Owns both HP registers.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting; accepts new_battle (wins) or start
// ST_ROLL  | one cycle: compare roll with accuracy, latch hit
// ST_DRAIN | tick divider; one HP point off the target per terminal count
// ST_DONE  | one cycle: done pulse, then back to idle
module move_resolver
    import pbs_pkg::*;
#(
    parameter int         MAX_HP    = 15,
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         DRAIN_DIV = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            new_battle,
    input  logic            start,
    input  logic            attacker,
    input  logic [3:0]      move_dmg,
    input  logic [3:0]      move_accu,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic            busy,
    output logic            done,
    output logic            hit,
    output logic            p_ko,
    output logic            ai_ko
);

    localparam int              CNT_W   = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DRAIN_DIV - 1);
    localparam logic [HP_W-1:0]  HP_INIT = HP_W'(MAX_HP);

    state_e           state_q;
    logic [HP_W-1:0]  p_hp_q;
    logic [HP_W-1:0]  ai_hp_q;
    logic             busy_q;
    logic             done_q;
    logic             hit_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       rem_q;
    logic             atk_q;
    logic [3:0]       dmg_q;
    logic [3:0]       accu_q;

    logic [7:0]       lfsr_q;
    logic [HP_W-1:0]  tgt_hp;
    logic             roll_hit;
    logic             unused_lfsr;

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .q       (lfsr_q)
    );

    // Upper LFSR bits are reserved for other consumers of the same generator.
    assign unused_lfsr = ^lfsr_q[7:4];

    always_comb begin
        tgt_hp   = (atk_q == ATK_AI) ? p_hp_q : ai_hp_q;
        roll_hit = roll_hits(lfsr_q[3:0], accu_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            p_hp_q  <= HP_INIT;
            ai_hp_q <= HP_INIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            atk_q   <= ATK_PLAYER;
            dmg_q   <= '0;
            accu_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (new_battle) begin
                        p_hp_q  <= HP_INIT;
                        ai_hp_q <= HP_INIT;
                    end else if (start) begin
                        atk_q   <= attacker;
                        dmg_q   <= move_dmg;
                        accu_q  <= move_accu;
                        state_q <= ST_ROLL;
                        busy_q  <= 1'b1;
                    end
                end
                ST_ROLL: begin
                    hit_q <= roll_hit;
                    if (roll_hit && (dmg_q != 4'd0)) begin
                        rem_q   <= dmg_q;
                        cnt_q   <= '0;
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (tgt_hp == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (cnt_q == CNT_TC) begin
                        cnt_q <= '0;
                        rem_q <= rem_q - 4'd1;
                        if (atk_q == ATK_AI) begin
                            p_hp_q <= p_hp_q - 1'b1;
                        end else begin
                            ai_hp_q <= ai_hp_q - 1'b1;
                        end
                        // Leave as soon as this tick empties either the damage or the HP.
                        if ((rem_q == 4'd1) || (tgt_hp == HP_W'(1))) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign p_hp  = p_hp_q;
    assign ai_hp = ai_hp_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign hit   = hit_q;
    assign p_ko  = (p_hp_q == '0);
    assign ai_ko = (ai_hp_q == '0);

endmodule

// File: tb/tb_move_resolver.sv
// Directed bench for move_resolver: one instance with DRAIN_DIV=1 for the main
// scenarios and one with DRAIN_DIV=4 for divider latency and mid-drain reset.
module tb_move_resolver;

    logic       clk = 1'b0;
    logic       reset_n, new_battle, start, attacker;
    logic [3:0] move_dmg, move_accu;
    logic [3:0] p_hp, ai_hp;
    logic       busy, done, hit, p_ko, ai_ko;

    logic       reset_n4, new_battle4, start4, attacker4;
    logic [3:0] move_dmg4, move_accu4;
    logic [3:0] p_hp4, ai_hp4;
    logic       busy4, done4, hit4, p_ko4, ai_ko4;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mdl_lfsr;

    always #5 clk = ~clk;

    move_resolver #(.MAX_HP(15), .LFSR_SEED(8'hA5), .DRAIN_DIV(1)) u_dut (
        .clk(clk), .reset_n(reset_n), .new_battle(new_battle), .start(start),
        .attacker(attacker), .move_dmg(move_dmg), .move_accu(move_accu),
        .p_hp(p_hp), .ai_hp(ai_hp), .busy(busy), .done(done), .hit(hit),
        .p_ko(p_ko), .ai_ko(ai_ko)
    );

    move_resolver #(.MAX_HP(15), .LFSR_SEED(8'hA5), .DRAIN_DIV(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n4), .new_battle(new_battle4), .start(start4),
        .attacker(attacker4), .move_dmg(move_dmg4), .move_accu(move_accu4),
        .p_hp(p_hp4), .ai_hp(ai_hp4), .busy(busy4), .done(done4), .hit(hit4),
        .p_ko(p_ko4), .ai_ko(ai_ko4)
    );

    // Reference LFSR for the DRAIN_DIV=1 instance, x^8+x^6+x^5+x^4+1.
    always @(posedge clk) begin
        if (!reset_n) mdl_lfsr <= 8'hA5;
        else          mdl_lfsr <= {mdl_lfsr[6:0], mdl_lfsr[7] ^ mdl_lfsr[5] ^ mdl_lfsr[4] ^ mdl_lfsr[3]};
    end

    // Issue start from IDLE; returns #1 after the accepting edge (FSM in ROLL).
    task automatic kick(input logic a, input logic [3:0] d, input logic [3:0] acc);
        start = 1'b1; attacker = a; move_dmg = d; move_accu = acc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts cycles from the start edge until done is seen; -1 on timeout.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) return;
        end
        lat = -1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; reset_n4 = 1'b0;
        new_battle = 0; start = 0; attacker = 0; move_dmg = 0; move_accu = 0;
        new_battle4 = 0; start4 = 0; attacker4 = 0; move_dmg4 = 0; move_accu4 = 0;
        repeat (3) @(posedge clk);
        #1; reset_n = 1'b1; reset_n4 = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (p_hp !== 4'd15) begin n_fail++; $display("FAIL reset_p_hp got %0d exp 15", p_hp); end
        n_checks++; if (ai_hp !== 4'd15) begin n_fail++; $display("FAIL reset_ai_hp got %0d exp 15", ai_hp); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b exp 0", hit); end
        n_checks++; if (p_ko !== 1'b0 || ai_ko !== 1'b0) begin n_fail++; $display("FAIL reset_ko got %b%b exp 00", p_ko, ai_ko); end
    endtask

    task automatic test_hit;
        logic [3:0] exp_hp [6] = '{4'd15, 4'd15, 4'd14, 4'd13, 4'd12, 4'd11};
        kick(1'b0, 4'd4, 4'd15);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (ai_hp !== exp_hp[k]) begin n_fail++; $display("FAIL hit_drain_step%0d got %0d exp %0d", k, ai_hp, exp_hp[k]); end
            n_checks++; if (done !== (k == 5)) begin n_fail++; $display("FAIL hit_done_step%0d got %b exp %b", k, done, (k == 5)); end
            if (k < 5) begin @(posedge clk); #1; end
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_flag got %b exp 1", hit); end
        n_checks++; if (p_hp !== 4'd15) begin n_fail++; $display("FAIL hit_nontarget got %0d exp 15", p_hp); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL hit_idle got busy %b done %b exp 0 0", busy, done); end
    endtask

    task automatic test_miss;
        int lat;
        kick(1'b1, 4'd9, 4'd0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL miss_busy got %b exp 1", busy); end
        wait_done(1, lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL miss_latency got %0d exp 2", lat); end
        n_checks++; if (hit !== 1'b0) begin n_fail++; $display("FAIL miss_hit got %b exp 0", hit); end
        n_checks++; if (p_hp !== 4'd15 || ai_hp !== 4'd11) begin n_fail++; $display("FAIL miss_hp got %0d/%0d exp 15/11", p_hp, ai_hp); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignored_pulses;
        int lat;
        kick(1'b1, 4'd2, 4'd15);
        start = 1'b1; new_battle = 1'b1; attacker = 1'b0; move_dmg = 4'd9; move_accu = 4'd15;
        @(posedge clk); #1;
        start = 1'b0; new_battle = 1'b0;
        wait_done(2, lat);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL busy_pulse_latency got %0d exp 4", lat); end
        n_checks++; if (p_hp !== 4'd13) begin n_fail++; $display("FAIL busy_pulse_p_hp got %0d exp 13", p_hp); end
        n_checks++; if (ai_hp !== 4'd11) begin n_fail++; $display("FAIL busy_pulse_ai_hp got %0d exp 11", ai_hp); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || ai_hp !== 4'd11) begin n_fail++; $display("FAIL busy_pulse_no_queue got busy %b ai_hp %0d exp 0 11", busy, ai_hp); end
    endtask

    task automatic test_simultaneous;
        new_battle = 1'b1; start = 1'b1; attacker = 1'b0; move_dmg = 4'd5; move_accu = 4'd15;
        @(posedge clk); #1;
        new_battle = 1'b0; start = 1'b0;
        n_checks++; if (p_hp !== 4'd15 || ai_hp !== 4'd15) begin n_fail++; $display("FAIL simul_reload got %0d/%0d exp 15/15", p_hp, ai_hp); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_busy got %b exp 0", busy); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0 || ai_hp !== 4'd15) begin n_fail++; $display("FAIL simul_start_dropped got busy %b ai_hp %0d exp 0 15", busy, ai_hp); end
    endtask

    task automatic test_overkill;
        int lat;
        int exp_lat [4] = '{8, 8, 5, 3};
        logic [3:0] exp_ai [4] = '{4'd9, 4'd3, 4'd0, 4'd0};
        for (int n = 0; n < 4; n++) begin
            kick(1'b0, 4'd6, 4'd15);
            wait_done(1, lat);
            n_checks++; if (lat !== exp_lat[n]) begin n_fail++; $display("FAIL overkill_latency%0d got %0d exp %0d", n, lat, exp_lat[n]); end
            n_checks++; if (ai_hp !== exp_ai[n]) begin n_fail++; $display("FAIL overkill_ai_hp%0d got %0d exp %0d", n, ai_hp, exp_ai[n]); end
            @(posedge clk); #1;
        end
        n_checks++; if (ai_ko !== 1'b1 || p_ko !== 1'b0) begin n_fail++; $display("FAIL overkill_ko got p %b ai %b exp 0 1", p_ko, ai_ko); end
        n_checks++; if (p_hp !== 4'd15 || hit !== 1'b1) begin n_fail++; $display("FAIL overkill_p_hp got %0d hit %b exp 15 1", p_hp, hit); end
        new_battle = 1'b1;
        @(posedge clk); #1;
        new_battle = 1'b0;
        n_checks++; if (ai_hp !== 4'd15 || ai_ko !== 1'b0) begin n_fail++; $display("FAIL new_battle_reload got %0d ko %b exp 15 0", ai_hp, ai_ko); end
    endtask

    task automatic test_hit_rate;
        int lat, n_hits, n_exp_hits;
        logic [3:0] acc, roll;
        logic exp_hit;
        n_hits = 0; n_exp_hits = 0;
        for (int t = 0; t < 200; t++) begin
            acc = 4'($urandom_range(0, 15));
            kick(1'($urandom_range(0, 1)), 4'd0, acc);
            roll = mdl_lfsr[3:0];
            exp_hit = (acc == 4'd15) || (roll < acc);
            wait_done(1, lat);
            n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rate_latency trial %0d got %0d exp 2", t, lat); end
            n_checks++; if (hit !== exp_hit) begin n_fail++; $display("FAIL rate_hit trial %0d accu %0d roll %0d got %b exp %b", t, acc, roll, hit, exp_hit); end
            n_hits += int'(hit);
            n_exp_hits += int'(exp_hit);
            @(posedge clk); #1;
        end
        n_checks++; if (n_hits !== n_exp_hits) begin n_fail++; $display("FAIL rate_total got %0d exp %0d", n_hits, n_exp_hits); end
        n_checks++; if (p_hp !== 4'd15 || ai_hp !== 4'd15) begin n_fail++; $display("FAIL rate_zero_dmg got %0d/%0d exp 15/15", p_hp, ai_hp); end
        $display("hit rate: %0d of 200 rolls hit", n_hits);
    endtask

    task automatic test_div4_latency;
        int lat;
        start4 = 1'b1; attacker4 = 1'b1; move_dmg4 = 4'd2; move_accu4 = 4'd15;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done4) break;
        end
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL div4_latency got %0d exp 10", lat); end
        n_checks++; if (p_hp4 !== 4'd13 || ai_hp4 !== 4'd15) begin n_fail++; $display("FAIL div4_hp got %0d/%0d exp 13/15", p_hp4, ai_hp4); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_drain_reset;
        start4 = 1'b1; attacker4 = 1'b0; move_dmg4 = 4'd5; move_accu4 = 4'd15;
        @(posedge clk); #1;
        start4 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (busy4 !== 1'b1 || ai_hp4 !== 4'd14) begin n_fail++; $display("FAIL mid_drain_pre got busy %b ai_hp %0d exp 1 14", busy4, ai_hp4); end
        reset_n4 = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL mid_drain_busy got %b exp 0", busy4); end
        n_checks++; if (ai_hp4 !== 4'd15 || p_hp4 !== 4'd15) begin n_fail++; $display("FAIL mid_drain_hp got %0d/%0d exp 15/15", p_hp4, ai_hp4); end
        n_checks++; if (hit4 !== 1'b0 || done4 !== 1'b0) begin n_fail++; $display("FAIL mid_drain_flags got hit %b done %b exp 0 0", hit4, done4); end
        reset_n4 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++; if (busy4 !== 1'b0 || ai_hp4 !== 4'd15) begin n_fail++; $display("FAIL mid_drain_after got busy %b ai_hp %0d exp 0 15", busy4, ai_hp4); end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_ignored_pulses();
        test_simultaneous();
        test_overkill();
        test_hit_rate();
        test_div4_latency();
        test_mid_drain_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

endmodule
